// File: rtl/serialize_lanes_if.sv
// Handshake bundle for serialize_lanes: a wide word input (din_*) and a
// narrow one-lane-per-beat output (dout_*).
// master: upstream producer / downstream consumer side (drives din_*, dout_ready)
// slave : the serializer itself
interface serialize_lanes_if #(
  parameter int LANES = 4,
  parameter int W     = 8
);
  localparam int CW = $clog2(LANES + 1);

  logic               din_valid;
  logic               din_ready;
  logic [LANES*W-1:0] din_data;
  logic [CW-1:0]      din_active;
  logic               dout_valid;
  logic               dout_ready;
  logic [W-1:0]       dout_data;
  logic               dout_last;

  modport master (
    output din_valid, din_data, din_active, dout_ready,
    input  din_ready, dout_valid, dout_data, dout_last
  );

  modport slave (
    input  din_valid, din_data, din_active, dout_ready,
    output din_ready, dout_valid, dout_data, dout_last
  );
endinterface

// File: rtl/serialize_lanes.sv
// serialize_lanes: accepts a word of LANES packed lanes plus an active-lane
// count, then emits lanes one per cycle, flagging the final one with dout_last.
// A word arriving on the last-lane handshake is loaded with no bubble.
// Optional build macro SERIALIZE_LANES_MSB_FIRST_EN: emit lanes k-1 down to 0
// instead of 0 up to k-1.
module serialize_lanes #(
  parameter int LANES = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  serialize_lanes_if.slave   s
);
  localparam int CW = $clog2(LANES + 1);
  localparam int IW = $clog2(LANES);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e                    state_q;
  logic [LANES-1:0][W-1:0]   data_q;
  logic [IW-1:0]             idx_q;
  logic [CW-1:0]             cnt_q;

  logic [CW-1:0]             act_cl;
  logic [CW-1:0]             act_m1;
  logic [IW-1:0]             start_idx;
  logic                      last_hs;
  logic                      din_hs;

  // Clamp the requested lane count and derive the first lane to emit.
  always_comb begin
    act_cl = (s.din_active > CW'(LANES)) ? CW'(LANES) : s.din_active;
    act_m1 = act_cl - CW'(1);
`ifdef SERIALIZE_LANES_MSB_FIRST_EN
    start_idx = act_m1[IW-1:0];
`else
    start_idx = '0;
`endif
  end

  // Last lane leaving this cycle frees the holding register for a new word,
  // so din_ready follows dout_ready combinationally in that case.
  assign last_hs     = (state_q == SEND) && s.dout_ready && (cnt_q == CW'(1));
  assign s.din_ready = !rst && ((state_q == IDLE) || last_hs);
  assign din_hs      = s.din_valid && s.din_ready;

  // Outputs come straight from held state, so they are stable under stall.
  assign s.dout_valid = (state_q == SEND);
  assign s.dout_data  = (state_q == SEND) ? data_q[idx_q] : '0;
  assign s.dout_last  = (state_q == SEND) && (cnt_q == CW'(1));

  // Serializer FSM: load on accept, step one lane per output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // A zero-lane word is accepted and dropped.
          if (din_hs && act_cl != '0) begin
            state_q <= SEND;
            data_q  <= s.din_data;
            idx_q   <= start_idx;
            cnt_q   <= act_cl;
          end
        end
        SEND: begin
          if (s.dout_ready) begin
            if (cnt_q == CW'(1)) begin
              if (din_hs && act_cl != '0) begin
                data_q <= s.din_data;
                idx_q  <= start_idx;
                cnt_q  <= act_cl;
              end else begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end
            end else begin
`ifdef SERIALIZE_LANES_MSB_FIRST_EN
              idx_q <= idx_q - IW'(1);
`else
              idx_q <= idx_q + IW'(1);
`endif
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serialize_lanes.sv
// Directed bench for serialize_lanes (LANES=4, W=8). Expected lane order
// follows SERIALIZE_LANES_MSB_FIRST_EN when that macro is defined.
module tb_serialize_lanes;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  serialize_lanes_if #(.LANES(4), .W(8)) bus ();

  serialize_lanes #(.LANES(4), .W(8)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // i-th emitted lane of a k-lane word
  function automatic logic [7:0] lane(input logic [31:0] d, input int i, input int k);
`ifdef SERIALIZE_LANES_MSB_FIRST_EN
    lane = d[8*(k-1-i) +: 8];
`else
    lane = d[8*i +: 8];
    if (k < 0) lane = '0;
`endif
  endfunction

  // Present one word with dout_ready held high and check k lanes come out.
  task automatic xfer(input string tag, input logic [31:0] d, input logic [2:0] act, input int k);
    bus.din_valid  = 1'b1;
    bus.din_data   = d;
    bus.din_active = act;
    bus.dout_ready = 1'b1;
    #1;
    chk({tag, ".rdy"}, 32'(bus.din_ready), 32'd1);
    tick();
    bus.din_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      chk({tag, ".vld"},  32'(bus.dout_valid), 32'd1);
      chk({tag, ".data"}, 32'(bus.dout_data), 32'(lane(d, i, k)));
      chk({tag, ".last"}, 32'(bus.dout_last), 32'(i == k-1));
      tick();
    end
    chk({tag, ".idle"}, 32'(bus.dout_valid), 32'd0);
  endtask

  initial begin
    bus.din_valid  = 1'b0;
    bus.din_data   = '0;
    bus.din_active = '0;
    bus.dout_ready = 1'b0;

    // reset state
    tick(); tick();
    chk("rst.din_ready",  32'(bus.din_ready),  32'd0);
    chk("rst.dout_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst.dout_last",  32'(bus.dout_last),  32'd0);
    chk("rst.dout_data",  32'(bus.dout_data),  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.din_ready", 32'(bus.din_ready), 32'd1);

    // basic 4-lane word
    xfer("basic", 32'h4433_2211, 3'd4, 4);

    // back-to-back words, din_valid held
    bus.din_valid = 1'b1; bus.din_data = 32'hDDCC_BBAA; bus.din_active = 3'd4;
    bus.dout_ready = 1'b1;
    tick();
    bus.din_data = 32'h0000_0099; bus.din_active = 3'd1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b.vld",  32'(bus.dout_valid), 32'd1);
      chk("b2b.data", 32'(bus.dout_data), 32'(lane(32'hDDCC_BBAA, i, 4)));
      chk("b2b.last", 32'(bus.dout_last), 32'(i == 3));
      chk("b2b.rdy",  32'(bus.din_ready), 32'(i == 3));
      tick();
    end
    bus.din_valid = 1'b0;
    chk("b2b2.vld",  32'(bus.dout_valid), 32'd1);
    chk("b2b2.data", 32'(bus.dout_data), 32'h99);
    chk("b2b2.last", 32'(bus.dout_last), 32'd1);
    tick();
    chk("b2b.idle", 32'(bus.dout_valid), 32'd0);

    // stall on the first lane of a 3-lane word
    bus.din_valid = 1'b1; bus.din_data = 32'h4433_2211; bus.din_active = 3'd3;
    bus.dout_ready = 1'b0;
    tick();
    bus.din_valid = 1'b0;
    chk("stall.vld0", 32'(bus.dout_valid), 32'd1);
    chk("stall.d0",   32'(bus.dout_data), 32'(lane(32'h4433_2211, 0, 3)));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("stall.hold", 32'(bus.dout_data), 32'(lane(32'h4433_2211, 0, 3)));
      chk("stall.vld",  32'(bus.dout_valid), 32'd1);
      chk("stall.last", 32'(bus.dout_last), 32'd0);
      chk("stall.rdy",  32'(bus.din_ready), 32'd0);
    end
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("resume.data", 32'(bus.dout_data), 32'(lane(32'h4433_2211, i, 3)));
      chk("resume.last", 32'(bus.dout_last), 32'(i == 2));
      tick();
    end
    chk("resume.idle", 32'(bus.dout_valid), 32'd0);

    // zero-lane word is consumed silently
    bus.din_valid = 1'b1; bus.din_data = 32'hCAFE_F00D; bus.din_active = 3'd0;
    #1;
    chk("zero.rdy", 32'(bus.din_ready), 32'd1);
    tick();
    bus.din_valid = 1'b0;
    chk("zero.vld",  32'(bus.dout_valid), 32'd0);
    chk("zero.rdy2", 32'(bus.din_ready), 32'd1);
    tick();
    chk("zero.vld2", 32'(bus.dout_valid), 32'd0);

    // over-range count clamps to 4 lanes
    xfer("clamp", 32'h8877_6655, 3'd7, 4);

    // reset mid-word, then a fresh word from its first lane
    bus.din_valid = 1'b1; bus.din_data = 32'h1234_5678; bus.din_active = 3'd4;
    bus.dout_ready = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    chk("mid.d0", 32'(bus.dout_data), 32'(lane(32'h1234_5678, 0, 4)));
    tick();
    chk("mid.d1", 32'(bus.dout_data), 32'(lane(32'h1234_5678, 1, 4)));
    tick();
    rst = 1'b1;
    #1;
    chk("mid.rst_rdy", 32'(bus.din_ready), 32'd0);
    tick();
    rst = 1'b0;
    chk("mid.vld",  32'(bus.dout_valid), 32'd0);
    chk("mid.data", 32'(bus.dout_data),  32'd0);
    xfer("fresh", 32'h8765_4321, 3'd4, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/serialize_lanes.md
# serialize_lanes

Downstream neighbour of the decouple buffer. It takes one wide word of LANES packed lanes plus an active-lane count over a valid/ready handshake. It then emits those lanes one per cycle on a narrow valid/ready output, and flags the final lane with dout_last. It is the standard width-reduction stage between wide buffered datapaths and narrow consumers.

## Interface
Parameters:
- LANES, 4, number of lanes per input word (≥2)
- W, 8, lane width in bits
- CW, $clog2(LANES+1), width of the active-count field (derived; not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- din_valid  in  1  input word valid
- din_ready  out  1  input word accepted when din_valid & din_ready
- din_data  in  LANES*W  packed lanes; lane i = din_data[i*W +: W]
- din_active  in  CW  number of lanes to emit, starting at lane 0
- dout_valid  out  1  output lane valid
- dout_ready  in  1  downstream accepts lane
- dout_data  out  W  current lane
- dout_last  out  1  high with the final lane of a word

## Operation
- Two states: IDLE (no word held) and SEND (word held in the data register, lane index idx, count cnt).
- IDLE: din_ready=1. On a din handshake, latch din_data and the clamped active count, then go to SEND with idx at its start value.
- Clamp rule: din_active > LANES is treated as LANES.
- din_active == 0: the word is accepted and discarded. The block stays in IDLE and emits nothing.
- SEND: dout_valid=1, dout_data = held lane[idx], dout_last = (remaining == 1). On a dout handshake that is not last, advance idx by one and decrement remaining.
- Last-lane handshake in SEND: din_ready=1 in that same cycle (combinational from dout_ready). If din_valid is also high, load the new word directly and stay in SEND; this is a back-to-back reload with no bubble. Otherwise go to IDLE.
- In SEND and not at the last-lane handshake, din_ready=0.
- dout_data and dout_last are stable while dout_valid & !dout_ready. The output must not change until the handshake.
- Arithmetic: idx and remaining are $clog2(LANES) and CW bits wide. They never wrap, because remaining reaches 1 before idx overflows.

## Timing
- Reset: while rst=1, din_ready=0, dout_valid=0, dout_last=0, dout_data=0, state=IDLE. din_ready=1 in the first cycle after rst deasserts.
- Latency: the first lane is valid on the cycle after the din handshake.
- Throughput: a word with k active lanes occupies exactly k output cycles under constant dout_ready. Back-to-back words sustain one lane per cycle.
- Asserting rst in SEND drops the held word immediately. The next cycle shows dout_valid=0. Partially sent words are not resumed.
- Combinational path dout_ready → din_ready exists. There is no combinational path din_valid → dout_valid.

## Configuration
- SERIALIZE_LANES_MSB_FIRST_EN undefined: lanes are emitted in order lane 0, 1, …, k-1.
- SERIALIZE_LANES_MSB_FIRST_EN defined: lanes are emitted in order lane k-1, k-2, …, 0. idx starts at k-1 and decrements. dout_last is still asserted with the final emitted lane (lane 0).
- Handshake, latency and throughput are identical in both builds.

## Test plan
- After reset with LANES=4, W=8: send din_data=0x44332211, active=4, dout_ready=1. Required: dout_data 0x11,0x22,0x33,0x44 on consecutive cycles; dout_last only on 0x44. Under MSB_FIRST the order is 0x44..0x11 with last on 0x11.
- Two words back-to-back, 0xDDCCBBAA (active=4) and 0x00000099 (active=1), din_valid held. Required: five consecutive dout cycles AA,BB,CC,DD,99 with no bubble; dout_last on DD and on 99.
- Stall: active=3, hold dout_ready=0 for 3 cycles after the first lane. Required: dout_data stays 0x11 and din_ready=0 throughout; the sequence resumes correctly.
- Boundaries: active=0 → word consumed, dout_valid never rises, din_ready returns to 1 the next cycle. active=7 (clamped to 4) → exactly 4 lanes emitted.
- Assert rst for 1 cycle after the second lane of a 4-lane word. Required: dout_valid=0 the cycle after rst, and a fresh word then serializes from its first lane.
